// File: rtl/filtro_pkg.sv
// rtl/filtro_pkg.sv - state encoding and width helper shared by the MAC sequencer files
package filtro_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CLR  = 2'd1,
    ST_MAC  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Select ports stay at least one bit wide even for a single tap or channel.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/filtro_wrap_cnt.sv
// rtl/filtro_wrap_cnt.sv - modulo-MOD up-counter with enable, sync clear and terminal-count flag
module filtro_wrap_cnt #(
  parameter int MOD = 5,
  parameter int W   = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         tc
);

  localparam logic [W-1:0] LAST = W'(MOD - 1);

  assign tc = (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tc ? '0 : cnt + W'(1);
    end
  end

endmodule

// File: rtl/filtro_mac_seq.sv
// rtl/filtro_mac_seq.sv - strobe-driven tap/channel sequencer for a shared MAC datapath
// FILTRO_MAC_PIPE_EN: delays acc_clr/acc_en/done one clk for a registered multiplier.
module filtro_mac_seq
  import filtro_pkg::*;
#(
  parameter int N_TAPS = 5,
  parameter int N_CH   = 1,
  parameter int SEL_W  = clog2_min1(N_TAPS),
  parameter int CH_W   = clog2_min1(N_CH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             ovr_clr,
  output logic [SEL_W-1:0] coef_sel,
  output logic [SEL_W-1:0] tap_sel,
  output logic [CH_W-1:0]  ch_sel,
  output logic             acc_clr,
  output logic             acc_en,
  output logic             busy,
  output logic             done,
  output logic             overrun
);

  state_e           state;
  state_e           state_nxt;
  logic             tap_clr;
  logic             tap_en;
  logic             tap_tc;
  logic             ch_clr;
  logic             ch_en;
  logic             ch_tc;
  logic [SEL_W-1:0] k;
  logic [CH_W-1:0]  ch;
  logic             hold;
  logic             clr_dec;
  logic             en_dec;
  logic             done_dec;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    tap_clr   = 1'b0;
    tap_en    = 1'b0;
    ch_clr    = 1'b0;
    ch_en     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start && !hold) begin
          state_nxt = ST_CLR;
          tap_clr   = 1'b1;
          ch_clr    = 1'b1;
        end
      end
      ST_CLR:  state_nxt = ST_MAC;
      ST_MAC: begin
        tap_en = 1'b1;
        if (tap_tc) begin
          if (ch_tc) begin
            state_nxt = ST_DONE;
          end else begin
            ch_en     = 1'b1;
            state_nxt = ST_CLR;
          end
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  filtro_wrap_cnt #(.MOD(N_TAPS), .W(SEL_W)) u_tap_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (tap_clr),
    .en    (tap_en),
    .cnt   (k),
    .tc    (tap_tc)
  );

  // Channel count is only cleared on a new strobe so ch_sel holds while idle.
  filtro_wrap_cnt #(.MOD(N_CH), .W(CH_W)) u_ch_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (ch_clr),
    .en    (ch_en),
    .cnt   (ch),
    .tc    (ch_tc)
  );

  assign clr_dec  = (state == ST_CLR);
  assign en_dec   = (state == ST_MAC);
  assign done_dec = (state == ST_DONE);

  assign coef_sel = k;
  assign tap_sel  = k;
  assign ch_sel   = ch;

`ifdef FILTRO_MAC_PIPE_EN
  logic clr_q;
  logic en_q;
  logic done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clr_q  <= 1'b0;
      en_q   <= 1'b0;
      done_q <= 1'b0;
    end else begin
      clr_q  <= clr_dec;
      en_q   <= en_dec;
      done_q <= done_dec;
    end
  end

  assign acc_clr = clr_q;
  assign acc_en  = en_q;
  assign done    = done_q;
  // The delayed done cycle still belongs to the running sequence.
  assign hold    = done_q;
`else
  assign acc_clr = clr_dec;
  assign acc_en  = en_dec;
  assign done    = done_dec;
  assign hold    = 1'b0;
`endif

  assign busy = (state != ST_IDLE) || hold;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun <= 1'b0;
    end else if (start && busy) begin
      overrun <= 1'b1;
    end else if (ovr_clr) begin
      overrun <= 1'b0;
    end
  end

endmodule
